// File: rtl/apb_timer_evt_gen_pkg.sv
// Shared types and defaults for the timer event generator.
package apb_timer_evt_gen_pkg;

  localparam int unsigned CNT_W_DEF     = 16;
  localparam int unsigned IRQ_CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2,
    ST_STOPPED  = 2'd3
  } state_e;

endpackage

// File: rtl/apb_timer_evt_gen_chan.sv
// One channel: period counter with event pulse, plus IRQ edge capture.
module apb_timer_evt_gen_chan
  import apb_timer_evt_gen_pkg::*;
#(
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned IRQ_CNT_W = IRQ_CNT_W_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 count_i,
  input  logic                 en_i,
  input  logic [CNT_W-1:0]     period_i,
  input  logic                 irq_i,
  input  logic                 ack_i,
  output logic                 event_o,
  output logic                 pend_o,
  output logic                 ovr_o,
  output logic [IRQ_CNT_W-1:0] irq_cnt_o
);

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     per_q, per_d;
  logic [CNT_W-1:0]     per_eff;
  logic                 evt_q, evt_d;
  logic                 prev_q, prev_d;
  logic                 pend_q, pend_d;
  logic                 ovr_q, ovr_d;
  logic [IRQ_CNT_W-1:0] icnt_q, icnt_d;
  logic                 edge_w;

  // A fresh period is taken whenever the counter sits at zero.
  assign per_eff = (cnt_q == '0) ? period_i : per_q;
  assign edge_w  = irq_i & ~prev_q;

  always_comb begin
    cnt_d = cnt_q;
    per_d = per_q;
    evt_d = 1'b0;
    if (!en_i) begin
      cnt_d = '0;
    end else if (count_i) begin
      if (per_eff == '0) begin
        cnt_d = '0;
      end else if (cnt_q == per_eff - CNT_W'(1)) begin
        evt_d = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        per_d = per_eff;
      end
    end
  end

  always_comb begin
    prev_d = irq_i;
    pend_d = pend_q;
    ovr_d  = ovr_q;
    icnt_d = icnt_q;
    if (ack_i) begin
      pend_d = 1'b0;
      ovr_d  = 1'b0;
    end
    // An edge wins over a same-cycle ack for pending, not overrun.
    if (edge_w) begin
      pend_d = 1'b1;
      if (pend_q && !ack_i) ovr_d = 1'b1;
      if (icnt_q != '1) icnt_d = icnt_q + IRQ_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      per_q  <= '0;
      evt_q  <= 1'b0;
      prev_q <= 1'b0;
      pend_q <= 1'b0;
      ovr_q  <= 1'b0;
      icnt_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      per_q  <= per_d;
      evt_q  <= evt_d;
      prev_q <= prev_d;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
      icnt_q <= icnt_d;
    end
  end

  assign event_o   = evt_q;
  assign pend_o    = pend_q;
  assign ovr_o     = ovr_q;
  assign irq_cnt_o = icnt_q;

endmodule

// File: rtl/apb_timer_evt_gen.sv
// Event generator and IRQ monitor for a timer under test.
module apb_timer_evt_gen
  import apb_timer_evt_gen_pkg::*;
#(
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned IRQ_CNT_W = IRQ_CNT_W_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_lo_i,
  input  logic                 en_hi_i,
  input  logic [CNT_W-1:0]     period_lo_i,
  input  logic [CNT_W-1:0]     period_hi_i,
  input  logic                 stop_req_i,
  input  logic                 busy_i,
  input  logic                 irq_lo_i,
  input  logic                 irq_hi_i,
  input  logic [1:0]           irq_ack_i,
  output logic                 event_lo_o,
  output logic                 event_hi_o,
  output logic                 stoptimer_o,
  output logic [1:0]           irq_pending_o,
  output logic [1:0]           overrun_o,
  output logic [IRQ_CNT_W-1:0] irq_cnt_lo_o,
  output logic [IRQ_CNT_W-1:0] irq_cnt_hi_o,
  output logic [1:0]           state_o
);

  state_e state_q, state_d;
  logic   stop_q, stop_d;
  logic   any_en;
  logic   count_w;

  assign any_en = en_lo_i | en_hi_i;
  // Counting is withheld on the cycle a stop is requested so no
  // event can surface while stoptimer_o is high.
  assign count_w = (state_q == ST_RUN) && !stop_req_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (stop_req_i)  state_d = ST_STOPPING;
        else if (any_en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (stop_req_i)   state_d = ST_STOPPING;
        else if (!any_en) state_d = ST_IDLE;
      end
      ST_STOPPING: begin
        if (!busy_i) state_d = ST_STOPPED;
      end
      ST_STOPPED: begin
        if (!stop_req_i) state_d = any_en ? ST_RUN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    stop_d = (state_d == ST_STOPPING) || (state_d == ST_STOPPED);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stop_q  <= stop_d;
    end
  end

  assign state_o     = state_q;
  assign stoptimer_o = stop_q;

  apb_timer_evt_gen_chan #(
    .CNT_W     (CNT_W),
    .IRQ_CNT_W (IRQ_CNT_W)
  ) u_lo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .count_i   (count_w),
    .en_i      (en_lo_i),
    .period_i  (period_lo_i),
    .irq_i     (irq_lo_i),
    .ack_i     (irq_ack_i[0]),
    .event_o   (event_lo_o),
    .pend_o    (irq_pending_o[0]),
    .ovr_o     (overrun_o[0]),
    .irq_cnt_o (irq_cnt_lo_o)
  );

  apb_timer_evt_gen_chan #(
    .CNT_W     (CNT_W),
    .IRQ_CNT_W (IRQ_CNT_W)
  ) u_hi (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .count_i   (count_w),
    .en_i      (en_hi_i),
    .period_i  (period_hi_i),
    .irq_i     (irq_hi_i),
    .ack_i     (irq_ack_i[1]),
    .event_o   (event_hi_o),
    .pend_o    (irq_pending_o[1]),
    .ovr_o     (overrun_o[1]),
    .irq_cnt_o (irq_cnt_hi_o)
  );

endmodule

// File: tb/tb_apb_timer_evt_gen.sv
// Bench: behavioural model plus directed and random stimulus.
module tb_apb_timer_evt_gen;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        en_lo_i = 0, en_hi_i = 0;
  logic [15:0] period_lo_i = 0, period_hi_i = 0;
  logic        stop_req_i = 0, busy_i = 0;
  logic        irq_lo_i = 0, irq_hi_i = 0;
  logic [1:0]  irq_ack_i = 0;
  logic        event_lo_o, event_hi_o, stoptimer_o;
  logic [1:0]  irq_pending_o, overrun_o, state_o;
  logic [7:0]  irq_cnt_lo_o, irq_cnt_hi_o;

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  apb_timer_evt_gen dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .en_lo_i       (en_lo_i),
    .en_hi_i       (en_hi_i),
    .period_lo_i   (period_lo_i),
    .period_hi_i   (period_hi_i),
    .stop_req_i    (stop_req_i),
    .busy_i        (busy_i),
    .irq_lo_i      (irq_lo_i),
    .irq_hi_i      (irq_hi_i),
    .irq_ack_i     (irq_ack_i),
    .event_lo_o    (event_lo_o),
    .event_hi_o    (event_hi_o),
    .stoptimer_o   (stoptimer_o),
    .irq_pending_o (irq_pending_o),
    .overrun_o     (overrun_o),
    .irq_cnt_lo_o  (irq_cnt_lo_o),
    .irq_cnt_hi_o  (irq_cnt_hi_o),
    .state_o       (state_o)
  );

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: ticks since last reload, period captured at reload.
  int m_state, m_stop;
  int m_ev[2], m_ticks[2], m_per[2];
  int m_prev[2], m_pend[2], m_ovr[2], m_icnt[2];

  always @(posedge clk) begin
    int run, en, pin, irq, ack, edg, nxt;
    if (rst_i) begin
      m_state = 0;
      m_stop = 0;
      for (int c = 0; c < 2; c++) begin
        m_ev[c] = 0; m_ticks[c] = 0; m_per[c] = 0;
        m_prev[c] = 0; m_pend[c] = 0; m_ovr[c] = 0;
        m_icnt[c] = 0;
      end
    end else begin
      run = (m_state == 1 && !stop_req_i) ? 1 : 0;
      for (int c = 0; c < 2; c++) begin
        en  = (c == 0) ? int'(en_lo_i) : int'(en_hi_i);
        pin = (c == 0) ? int'(period_lo_i) : int'(period_hi_i);
        irq = (c == 0) ? int'(irq_lo_i) : int'(irq_hi_i);
        ack = int'(irq_ack_i[c]);
        m_ev[c] = 0;
        if (en == 0) begin
          m_ticks[c] = 0;
        end else if (run == 1) begin
          if (m_ticks[c] == 0) m_per[c] = pin;
          if (m_per[c] != 0) begin
            m_ticks[c]++;
            if (m_ticks[c] == m_per[c]) begin
              m_ev[c] = 1;
              m_ticks[c] = 0;
            end
          end
        end
        edg = (irq == 1 && m_prev[c] == 0) ? 1 : 0;
        m_prev[c] = irq;
        if (edg == 1) begin
          if (m_pend[c] == 1 && ack == 0) m_ovr[c] = 1;
          m_pend[c] = 1;
          if (m_icnt[c] < 255) m_icnt[c]++;
        end
        if (ack == 1) begin
          m_ovr[c] = 0;
          if (edg == 0) m_pend[c] = 0;
        end
      end
      nxt = m_state;
      case (m_state)
        0: if (stop_req_i) nxt = 2;
           else if (en_lo_i || en_hi_i) nxt = 1;
        1: if (stop_req_i) nxt = 2;
           else if (!en_lo_i && !en_hi_i) nxt = 0;
        2: if (!busy_i) nxt = 3;
        default: if (!stop_req_i) nxt = (en_lo_i || en_hi_i) ? 1 : 0;
      endcase
      m_state = nxt;
      m_stop = (m_state >= 2) ? 1 : 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", int'(state_o), m_state);
      chk("stoptimer", int'(stoptimer_o), m_stop);
      chk("event_lo", int'(event_lo_o), m_ev[0]);
      chk("event_hi", int'(event_hi_o), m_ev[1]);
      chk("pend_lo", int'(irq_pending_o[0]), m_pend[0]);
      chk("pend_hi", int'(irq_pending_o[1]), m_pend[1]);
      chk("ovr_lo", int'(overrun_o[0]), m_ovr[0]);
      chk("ovr_hi", int'(overrun_o[1]), m_ovr[1]);
      chk("cnt_lo", int'(irq_cnt_lo_o), m_icnt[0]);
      chk("cnt_hi", int'(irq_cnt_hi_o), m_icnt[1]);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic quiet();
    en_lo_i = 0; en_hi_i = 0;
    period_lo_i = 0; period_hi_i = 0;
    stop_req_i = 0; busy_i = 0;
    irq_lo_i = 0; irq_hi_i = 0;
    irq_ack_i = 0;
  endtask

  task automatic do_reset();
    quiet();
    rst_i = 1;
    tick();
    rst_i = 0;
  endtask

  initial begin
    rst_i = 1;
    tick();
    tick();
    chk_en = 1;
    chk("rst_state", int'(state_o), 0);
    chk("rst_pend", int'(irq_pending_o), 0);
    rst_i = 0;

    // Period 4 on the low channel only.
    en_lo_i = 1;
    period_lo_i = 4;
    tick();
    chk("run_entry", int'(state_o), 1);
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("p4_ev_lo", int'(event_lo_o), (k % 4 == 0) ? 1 : 0);
      chk("p4_ev_hi", int'(event_hi_o), 0);
    end

    // Stop with busy held, then resume with the remaining count.
    do_reset();
    en_lo_i = 1;
    period_lo_i = 10;
    tick();
    repeat (3) tick();
    stop_req_i = 1;
    busy_i = 1;
    for (int s = 1; s <= 3; s++) begin
      tick();
      chk("stopping", int'(state_o), 2);
      chk("stop_o", int'(stoptimer_o), 1);
      chk("stop_ev", int'(event_lo_o), 0);
    end
    busy_i = 0;
    tick();
    chk("stopped", int'(state_o), 3);
    chk("stopped_o", int'(stoptimer_o), 1);
    stop_req_i = 0;
    tick();
    chk("resumed", int'(state_o), 1);
    chk("resumed_o", int'(stoptimer_o), 0);
    for (int r = 1; r <= 7; r++) begin
      tick();
      chk("resume_ev", int'(event_lo_o), (r == 7) ? 1 : 0);
    end

    // Two edges without ack, then ack.
    do_reset();
    irq_lo_i = 1;
    tick();
    chk("lat_pend", int'(irq_pending_o[0]), 1);
    irq_lo_i = 0;
    tick();
    irq_lo_i = 1;
    tick();
    irq_lo_i = 0;
    tick();
    chk("ov_pend", int'(irq_pending_o[0]), 1);
    chk("ov_flag", int'(overrun_o[0]), 1);
    chk("ov_cnt", int'(irq_cnt_lo_o), 2);
    irq_ack_i = 2'b01;
    tick();
    irq_ack_i = 0;
    chk("ack_pend", int'(irq_pending_o[0]), 0);
    chk("ack_ovr", int'(overrun_o[0]), 0);
    chk("ack_cnt", int'(irq_cnt_lo_o), 2);

    // Edge coinciding with ack on the high channel.
    do_reset();
    irq_hi_i = 1;
    tick();
    irq_hi_i = 0;
    tick();
    irq_hi_i = 1;
    irq_ack_i = 2'b10;
    tick();
    irq_ack_i = 0;
    chk("sim_pend", int'(irq_pending_o[1]), 1);
    chk("sim_ovr", int'(overrun_o[1]), 0);
    chk("sim_cnt", int'(irq_cnt_hi_o), 2);

    // Saturation.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      irq_lo_i = 1;
      tick();
      irq_lo_i = 0;
      tick();
    end
    chk("sat_cnt", int'(irq_cnt_lo_o), 255);

    // Reset during RUN with pending flags and a simultaneous ack/edge.
    do_reset();
    en_lo_i = 1;
    period_lo_i = 3;
    irq_lo_i = 1;
    irq_hi_i = 1;
    tick();
    tick();
    irq_lo_i = 0;
    irq_hi_i = 0;
    tick();
    chk("pre_pend", int'(irq_pending_o), 3);
    rst_i = 1;
    irq_ack_i = 2'b11;
    irq_lo_i = 1;
    tick();
    chk("mr_state", int'(state_o), 0);
    chk("mr_pend", int'(irq_pending_o), 0);
    chk("mr_ovr", int'(overrun_o), 0);
    chk("mr_cnt", int'(irq_cnt_lo_o), 0);
    chk("mr_ev", int'(event_lo_o), 0);
    chk("mr_stop", int'(stoptimer_o), 0);
    do_reset();

    // Random traffic against the model.
    for (int i = 0; i < 5000; i++) begin
      rst_i = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 39) == 0) en_lo_i = ~en_lo_i;
      if ($urandom_range(0, 39) == 0) en_hi_i = ~en_hi_i;
      if ($urandom_range(0, 29) == 0)
        period_lo_i = 16'($urandom_range(0, 7));
      if ($urandom_range(0, 29) == 0)
        period_hi_i = 16'($urandom_range(0, 7));
      if ($urandom_range(0, 24) == 0) stop_req_i = ~stop_req_i;
      busy_i = ($urandom_range(0, 2) == 0);
      irq_lo_i = $urandom_range(0, 1) == 1;
      irq_hi_i = $urandom_range(0, 3) == 0;
      irq_ack_i = 2'($urandom_range(0, 3) & {2{$urandom_range(0, 5) == 0}});
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_timer_evt_gen.md
APB_TIMER_EVT_GEN -- requirements
Module: apb_timer_evt_gen

Interface
REQ-001 Parameter CNT_W, default 16, SHALL set period counter width.
REQ-002 Parameter IRQ_CNT_W, default 8, SHALL set per-channel IRQ event counter width.
REQ-003 clk_i  in  1  single clock; all logic SHALL be rising-edge clk_i.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 en_lo_i / en_hi_i  in  1 each  channel enable, level.
REQ-006 period_lo_i / period_hi_i  in  CNT_W each  event period in cycles, sampled at reload.
REQ-007 stop_req_i  in  1  level request to freeze the timer under test.
REQ-008 busy_i  in  1  timer busy indication from timer under test.
REQ-009 irq_lo_i / irq_hi_i  in  1 each  interrupt lines from timer under test.
REQ-010 irq_ack_i  in  2  per-channel acknowledge, bit0=lo, bit1=hi, single-cycle.
REQ-011 event_lo_o / event_hi_o  out  1 each  single-cycle event pulses to timer under test.
REQ-012 stoptimer_o  out  1  stop request to timer under test.
REQ-013 irq_pending_o  out  2  sticky captured-IRQ flags, bit0=lo, bit1=hi.
REQ-014 overrun_o  out  2  sticky flag, IRQ edge seen while pending already set.
REQ-015 irq_cnt_lo_o / irq_cnt_hi_o  out  IRQ_CNT_W each  saturating IRQ edge counts.
REQ-016 state_o  out  2  current FSM state encoding.

Function
REQ-017 FSM states SHALL be IDLE=0, RUN=1, STOPPING=2, STOPPED=3.
REQ-018 IDLE->RUN when en_lo_i or en_hi_i is 1; RUN->IDLE when both are 0 and stop_req_i is 0.
REQ-019 RUN or IDLE ->STOPPING when stop_req_i=1; STOPPING->STOPPED on first cycle with busy_i=0; STOPPED->RUN (or IDLE if no enable) when stop_req_i=0.
REQ-020 stoptimer_o SHALL be 1 exactly in STOPPING and STOPPED, registered from state.
REQ-021 Per channel, in RUN with enable=1, counter SHALL increment each cycle; at count==period-1, the event output SHALL pulse high for one cycle and the counter SHALL reload to 0, sampling a new period.
REQ-022 Period 0 SHALL produce no events; period 1 SHALL produce an event every cycle.
REQ-023 Counters SHALL hold value in STOPPING/STOPPED and resume without loss; no events SHALL be issued while stoptimer_o=1.
REQ-024 Deasserting a channel enable SHALL clear that channel counter to 0 the next cycle.
REQ-025 IRQ capture SHALL detect rising edges of irq_*_i with a one-flop registered previous value; a level held high SHALL count once.
REQ-026 On edge: pending bit set, count incremented, saturating at all-ones; if pending already 1, overrun bit set.
REQ-027 irq_ack_i bit SHALL clear matching pending and overrun bits; simultaneous edge and ack SHALL leave pending=1, overrun=0, count incremented.
REQ-028 IRQ capture SHALL operate in every FSM state.
REQ-029 Latency: edge on irq_*_i at cycle N SHALL be visible on irq_pending_o at cycle N+1.

Reset
REQ-030 rst_i=1 SHALL force state IDLE, counters 0, event outputs 0, stoptimer_o 0, irq_pending_o 0, overrun_o 0, IRQ counts 0, edge-detect flops 0.
REQ-031 Reset mid-operation SHALL take effect on the next clock edge and override all other inputs, including simultaneous ack or edge.

Structure
REQ-032 Package apb_timer_evt_gen_pkg SHALL hold the FSM state enum typedef and default CNT_W/IRQ_CNT_W constants.
REQ-033 Sub-module apb_timer_evt_gen_chan SHALL implement one channel (period counter, event pulse, IRQ capture), instantiated twice; FSM lives in top.

Verification
REQ-034 en_lo_i=1, period_lo_i=4 for 20 cycles -> event_lo_o pulses at cycles 4,8,12,16,20 after entering RUN, event_hi_o stays 0.
REQ-035 Running period 10, stop_req_i=1 with busy_i=1 for 3 cycles -> stoptimer_o=1, state STOPPING 3 cycles then STOPPED, no events; release -> next event after remaining count.
REQ-036 irq_lo_i rising twice without ack -> irq_pending_o[0]=1, overrun_o[0]=1, irq_cnt_lo_o=2; ack -> both flags 0, count 2.
REQ-037 irq_hi_i edge same cycle as irq_ack_i[1] -> irq_pending_o[1]=1, overrun_o[1]=0, irq_cnt_hi_o incremented.
REQ-038 300 irq_lo_i edges -> irq_cnt_lo_o saturates at 255.
REQ-039 rst_i pulse during RUN with pending IRQs -> all outputs at reset values next cycle, state IDLE.
